onfi_wb_regs: RTL

//   Wishbone classic responder (slave) and CSR bank of the ONFI controller.
//   It answers the single read/write accesses issued by the system-side Wishbone master.
//   It holds the control, flash address and command registers, and hands each command
//   to the ONFI core with a valid/ready handshake. It also collects core status into a

---
 rtl/onfi_wb_regs.sv | 111 +++++++++++
 1 files changed

// File: rtl/onfi_wb_regs.sv
// Wishbone classic responder and CSR bank for the ONFI controller.
// Holds CTRL/ADDR/CMD registers, hands commands to the core, tracks a sticky done flag.
module onfi_wb_regs #(
  parameter int          MM_DATA_W = 32,
  parameter int          MM_ADDR_W = 8,
  parameter logic [31:0] ID_VALUE  = 32'h04F1_0100
) (
  input  logic                 mm_clk_i,
  input  logic                 mm_rst_i,
  input  logic                 mm_cyc_i,
  input  logic                 mm_stb_i,
  input  logic [MM_ADDR_W-1:0] mm_addr_i,
  input  logic [MM_DATA_W-1:0] mm_dat_i,
  output logic [MM_DATA_W-1:0] mm_dat_o,
  input  logic                 mm_we_i,
  output logic                 mm_ack_o,
  output logic                 mm_err_o,
  output logic [31:0]          ctrl_o,
  output logic [31:0]          flash_addr_o,
  output logic [7:0]           cmd_o,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  input  logic                 core_busy_i,
  input  logic                 core_done_i,
  output logic                 irq_o
);

  localparam logic [MM_ADDR_W-1:0] A_ID     = MM_ADDR_W'(8'h00);
  localparam logic [MM_ADDR_W-1:0] A_CTRL   = MM_ADDR_W'(8'h04);
  localparam logic [MM_ADDR_W-1:0] A_ADDR   = MM_ADDR_W'(8'h08);
  localparam logic [MM_ADDR_W-1:0] A_CMD    = MM_ADDR_W'(8'h0C);
  localparam logic [MM_ADDR_W-1:0] A_STATUS = MM_ADDR_W'(8'h10);

  logic        done_q;
  logic        accept;
  logic        resp_ok;
  logic        wr_ctrl, wr_addr, wr_cmd, w1c_done;
  logic [31:0] rd_word;
  logic [31:0] wdata;

  // A new request is only taken when no response is in flight, so a held strobe
  // gets one response every other cycle.
  assign accept = mm_cyc_i & mm_stb_i & ~mm_ack_o & ~mm_err_o;
  assign wdata  = 32'(mm_dat_i);
  assign irq_o  = done_q & ctrl_o[0];

  // Unaligned addresses never match a register, so they fall into the error path.
  always_comb begin
    resp_ok  = 1'b0;
    rd_word  = '0;
    wr_ctrl  = 1'b0;
    wr_addr  = 1'b0;
    wr_cmd   = 1'b0;
    w1c_done = 1'b0;
    case (mm_addr_i)
      A_ID: begin
        resp_ok = ~mm_we_i;
        rd_word = ID_VALUE;
      end
      A_CTRL: begin
        resp_ok = 1'b1;
        rd_word = ctrl_o;
        wr_ctrl = mm_we_i;
      end
      A_ADDR: begin
        resp_ok = 1'b1;
        rd_word = flash_addr_o;
        wr_addr = mm_we_i;
      end
      A_CMD: begin
        resp_ok = ~(mm_we_i & cmd_valid_o);
        rd_word = {23'b0, cmd_valid_o, cmd_o};
        wr_cmd  = mm_we_i & ~cmd_valid_o;
      end
      A_STATUS: begin
        resp_ok  = 1'b1;
        rd_word  = {29'b0, cmd_valid_o, done_q, core_busy_i};
        w1c_done = mm_we_i & wdata[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge mm_clk_i or posedge mm_rst_i) begin
    if (mm_rst_i) begin
      mm_ack_o     <= 1'b0;
      mm_err_o     <= 1'b0;
      mm_dat_o     <= '0;
      ctrl_o       <= '0;
      flash_addr_o <= '0;
      cmd_o        <= '0;
      cmd_valid_o  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      mm_ack_o <= accept & resp_ok;
      mm_err_o <= accept & ~resp_ok;
      mm_dat_o <= (accept & resp_ok & ~mm_we_i) ? MM_DATA_W'(rd_word) : '0;
      if (accept & wr_ctrl) ctrl_o <= wdata;
      if (accept & wr_addr) flash_addr_o <= wdata;
      if (accept & wr_cmd) begin
        cmd_o       <= wdata[7:0];
        cmd_valid_o <= 1'b1;
      end else if (cmd_valid_o & cmd_ready_i) begin
        cmd_valid_o <= 1'b0;
      end
      // A completion arriving with a W1C keeps the flag set.
      done_q <= core_done_i | (done_q & ~(accept & w1c_done));
    end
  end

endmodule
